// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for bit_serial_adder: FSM state encodings and counter sizing.
package bit_serial_adder_defs;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] RUN  = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   // Bit counter must reach WIDTH-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned w);
      int unsigned cw;
      cw = $clog2(w);
      return (cw < 1) ? 1 : cw;
   endfunction

endpackage

// File: rtl/bit_serial_adder_cell.sv
// serial_fa_cell: purely combinational 1-bit full adder used by bit_serial_adder.
module serial_fa_cell (
   input  logic in1,
   input  logic in2,
   input  logic c_in,
   output logic sum,
   output logic c_out
);

   assign sum   = in1 ^ in2 ^ c_in;
   assign c_out = (in1 & in2) | (in1 & c_in) | (in2 & c_in);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell with registered carry.
// Optional signed-overflow output enabled by defining BIT_SERIAL_ADD_OVF_EN.
module bit_serial_adder
   import bit_serial_adder_defs::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef BIT_SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             c_out_q;
   logic             cell_s;
   logic             cell_co;
`ifdef BIT_SERIAL_ADD_OVF_EN
   logic             ovf_q;
`endif

   serial_fa_cell u_cell (
      .in1   (a_sr[0]),
      .in2   (b_sr[0]),
      .c_in  (carry),
      .sum   (cell_s),
      .c_out (cell_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         sum_sr  <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         c_out_q <= 1'b0;
`ifdef BIT_SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr    <= a;
                  b_sr    <= b;
                  carry   <= c_in;
                  cnt     <= '0;
                  sum_sr  <= '0;
                  c_out_q <= 1'b0;
`ifdef BIT_SERIAL_ADD_OVF_EN
                  ovf_q   <= 1'b0;
`endif
                  state   <= RUN;
               end
            end
            RUN: begin
               sum_sr <= {cell_s, sum_sr[WIDTH-1:1]};
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               carry  <= cell_co;
               cnt    <= cnt + CW'(1);
               if (cnt == LAST) begin
                  // carry here is the carry entering the MSB
                  c_out_q <= cell_co;
`ifdef BIT_SERIAL_ADD_OVF_EN
                  ovf_q   <= carry ^ cell_co;
`endif
                  state   <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign busy  = (state == RUN) || (state == DONE);
   assign done  = (state == DONE);
   assign sum   = sum_sr;
   assign c_out = c_out_q;
`ifdef BIT_SERIAL_ADD_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule
